// File: rtl/mem_chk_pkg.sv
// mem_chk_pkg: shared state and failure-code types for the data-memory write checker.
package mem_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
    typedef enum logic [1:0] {NONE, MISMATCH, TIMEOUT, EMPTY} fail_code_t;

endpackage

// File: rtl/mem_write_checker_if.sv
// mem_write_checker_if: core data-memory write port tapped by the checker.
//   memwrite  store strobe
//   dataadr   store address
//   writedata store data
// master = core side (drives), slave = checker side (observes).
interface mem_write_checker_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);

endinterface

// File: rtl/mem_chk_table.sv
// mem_chk_table: DEPTH x (addr,data) expected-write register file.
//   clk/reset     clock, async active-low reset (clears every entry)
//   we/widx       write strobe and entry index (out-of-range index ignored)
//   waddr/wdata   entry contents
//   ridx          combinational read index -> raddr/rdata
module mem_chk_table #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [AW+DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we && 32'(widx) < DEPTH) mem_d[widx] = {waddr, wdata};
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) mem_q <= '{default: '0};
        else mem_q <= mem_d;

    assign {raddr, rdata} = mem_q[ridx];

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares core stores against an ordered expected-write list.
//   clk/reset        core clock, async active-low reset
//   start            arm a check (pulse); exp_count sampled here
//   exp_we/idx/addr/data  table programming, honoured outside RUN only
//   bus              observed store port (memwrite/dataadr/writedata)
//   busy/pass/fail   registered status; pass/fail sticky until start or reset
//   fail_code        NONE/MISMATCH/TIMEOUT/EMPTY
//   fail_idx         entry being matched when the failure occurred
//   cycles           RUN cycle counter, frozen once the check completes
module mem_write_checker
    import mem_chk_pkg::chk_state_t, mem_chk_pkg::fail_code_t,
           mem_chk_pkg::IDLE, mem_chk_pkg::RUN, mem_chk_pkg::PASS, mem_chk_pkg::FAIL,
           mem_chk_pkg::NONE, mem_chk_pkg::MISMATCH, mem_chk_pkg::EMPTY;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1024,
    parameter int TOL_EN   = 1,
    parameter int TOL_ADDR = 80,
    parameter int IW       = $clog2(DEPTH),
    parameter int NW       = $clog2(DEPTH + 1),
    parameter int CW       = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                exp_we,
    input  logic [IW-1:0]       exp_idx,
    input  logic [AW-1:0]       exp_addr,
    input  logic [DW-1:0]       exp_data,
    input  logic [NW-1:0]       exp_count,
    mem_write_checker_if.slave  bus,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          fail_code,
    output logic [IW-1:0]       fail_idx,
    output logic [CW-1:0]       cycles
);

    chk_state_t    state_q, state_d;
    fail_code_t    code_q, code_d;
    logic [IW-1:0] idx_q, idx_d, fidx_q, fidx_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_data;
    logic          hit, last, tol, tmo;

    mem_chk_table #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we && state_q != RUN),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (idx_q),
        .raddr (ref_addr),
        .rdata (ref_data)
    );

    // Tolerance is only consulted after the store misses the current entry.
    assign hit  = bus.memwrite && bus.dataadr == ref_addr && bus.writedata == ref_data;
    assign last = 32'(idx_q) + 1 == 32'(cnt_q);
    assign tol  = TOL_EN != 0 && bus.dataadr == AW'(TOL_ADDR);
    assign tmo  = 32'(cyc_q) == TIMEOUT - 1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        fidx_d  = fidx_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = exp_count == '0 ? FAIL : RUN;
                code_d  = exp_count == '0 ? EMPTY : NONE;
                cnt_d   = 32'(exp_count) > DEPTH ? NW'(DEPTH) : exp_count;
                idx_d   = '0;
                fidx_d  = '0;
                cyc_d   = '0;
            end
        end else begin
            // Priority: final match beats timeout; mismatch beats timeout.
            if (hit && last) begin
                state_d = PASS;
            end else if (bus.memwrite && !hit && !tol) begin
                state_d = FAIL;
                code_d  = MISMATCH;
                fidx_d  = idx_q;
            end else if (tmo) begin
                state_d = FAIL;
                code_d  = mem_chk_pkg::TIMEOUT;
                fidx_d  = idx_q;
            end else begin
                idx_d = hit ? idx_q + 1'b1 : idx_q;
                cyc_d = 32'(cyc_q) == TIMEOUT ? cyc_q : cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= NONE;
            idx_q   <= '0;
            fidx_q  <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            fidx_q  <= fidx_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end

    assign busy      = state_q == RUN;
    assign pass      = state_q == PASS;
    assign fail      = state_q == FAIL;
    assign fail_code = code_q;
    assign fail_idx  = fidx_q;
    assign cycles    = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: three checker instances (tolerance variants) against a list-level model.
module tb_mem_write_checker;

    logic        clk = 0;
    logic        reset = 0;
    logic        start = 0;
    logic        exp_we = 0;
    logic [1:0]  exp_idx = 0;
    logic [31:0] exp_addr = 0;
    logic [31:0] exp_data = 0;
    logic [2:0]  exp_count = 0;
    logic        busy_o [3];
    logic        pass_o [3];
    logic        fail_o [3];
    logic [1:0]  code_o [3];
    logic [1:0]  fidx_o [3];
    logic [4:0]  cyc_o  [3];
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    mem_write_checker_if #(.AW(32), .DW(32)) bus ();

    always #5 clk = ~clk;

    mem_write_checker #(.TIMEOUT(16), .TOL_EN(1), .TOL_ADDR(80)) u0 (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count), .bus(bus),
        .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .fail_code(code_o[0]),
        .fail_idx(fidx_o[0]), .cycles(cyc_o[0]));
    mem_write_checker #(.TIMEOUT(16), .TOL_EN(0), .TOL_ADDR(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count), .bus(bus),
        .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .fail_code(code_o[1]),
        .fail_idx(fidx_o[1]), .cycles(cyc_o[1]));
    mem_write_checker #(.TIMEOUT(16), .TOL_EN(1), .TOL_ADDR(4)) u2 (
        .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count), .bus(bus),
        .busy(busy_o[2]), .pass(pass_o[2]), .fail(fail_o[2]), .fail_code(code_o[2]),
        .fail_idx(fidx_o[2]), .cycles(cyc_o[2]));

    // Model: list of expected writes, a cursor, a cycle count, and a verdict.
    int te   [3] = '{1, 0, 1};
    int tadr [3] = '{80, 4, 4};
    int ta [3][4];
    int td [3][4];
    bit m_busy [3];
    bit m_pass [3];
    bit m_fail [3];
    int m_code [3];
    int m_fidx [3];
    int m_cyc  [3];
    int m_idx  [3];
    int m_cnt  [3];

    initial forever begin
        @(posedge clk or negedge reset);
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_busy[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
                m_code[k] = 0; m_fidx[k] = 0; m_cyc[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
                for (int j = 0; j < 4; j++) begin ta[k][j] = 0; td[k][j] = 0; end
            end else if (!m_busy[k]) begin
                if (exp_we) begin ta[k][exp_idx] = int'(exp_addr); td[k][exp_idx] = int'(exp_data); end
                if (start) begin
                    m_pass[k] = 0; m_fidx[k] = 0; m_cyc[k] = 0; m_idx[k] = 0;
                    m_cnt[k]  = exp_count > 4 ? 4 : int'(exp_count);
                    m_busy[k] = exp_count != 0;
                    m_fail[k] = exp_count == 0;
                    m_code[k] = exp_count == 0 ? 3 : 0;
                end
            end else begin
                bit matched;
                bit stray;
                matched = bus.memwrite && int'(bus.dataadr) == ta[k][m_idx[k]] &&
                          int'(bus.writedata) == td[k][m_idx[k]];
                stray = bus.memwrite && !matched && !(te[k] == 1 && int'(bus.dataadr) == tadr[k]);
                if (matched && m_idx[k] == m_cnt[k] - 1) begin
                    m_busy[k] = 0; m_pass[k] = 1;
                end else if (stray || m_cyc[k] == 15) begin
                    m_busy[k] = 0; m_fail[k] = 1;
                    m_code[k] = stray ? 1 : 2;
                    m_fidx[k] = m_idx[k];
                end else begin
                    m_idx[k] += matched ? 1 : 0;
                    m_cyc[k] = m_cyc[k] >= 16 ? 16 : m_cyc[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en && reset)
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("u%0d.busy", k), 32'(busy_o[k]), 32'(m_busy[k]));
                chk($sformatf("u%0d.pass", k), 32'(pass_o[k]), 32'(m_pass[k]));
                chk($sformatf("u%0d.fail", k), 32'(fail_o[k]), 32'(m_fail[k]));
                chk($sformatf("u%0d.fail_code", k), 32'(code_o[k]), m_code[k]);
                chk($sformatf("u%0d.fail_idx", k), 32'(fidx_o[k]), m_fidx[k]);
                chk($sformatf("u%0d.cycles", k), 32'(cyc_o[k]), m_cyc[k]);
            end

    task automatic prog(input int i, input int a, input int d);
        exp_we = 1; exp_idx = 2'(i); exp_addr = a; exp_data = d;
        @(negedge clk);
        exp_we = 0;
    endtask

    task automatic go(input int n);
        exp_count = 3'(n); start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic st(input int a, input int d);
        bus.memwrite = 1; bus.dataadr = a; bus.writedata = d;
        @(negedge clk);
        bus.memwrite = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0;
        idle(2);
        reset = 1; chk_en = 1;
        chk("rst.busy", 32'(busy_o[0]), 0);
        chk("rst.pass", 32'(pass_o[0]), 0);
        chk("rst.fail", 32'(fail_o[0]), 0);
        chk("rst.cycles", 32'(cyc_o[0]), 0);
        // 1: tolerated scratch store then the expected one
        prog(0, 84, 7); go(1); st(80, 0); st(84, 7);
        chk("t1.pass", 32'(pass_o[0]), 1);
        chk("t1.fail", 32'(fail_o[0]), 0);
        chk("t1.cycles", 32'(cyc_o[0]), 1);
        chk("t1.u1_code", 32'(code_o[1]), 1);
        // 2: wrong address
        go(1); st(88, 7);
        chk("t2.fail", 32'(fail_o[0]), 1);
        chk("t2.code", 32'(code_o[0]), 1);
        chk("t2.fidx", 32'(fidx_o[0]), 0);
        chk("t2.busy", 32'(busy_o[0]), 0);
        // 3: skipped entry, then in-order rerun
        prog(0, 4, 1); prog(1, 8, 2); prog(2, 12, 3);
        go(3); st(4, 1); st(12, 3);
        chk("t3.code", 32'(code_o[0]), 1);
        chk("t3.fidx", 32'(fidx_o[0]), 1);
        chk("t3.u2_fidx", 32'(fidx_o[2]), 1);
        go(3); st(4, 1); idle(1); st(8, 2); st(12, 3);
        chk("t3.pass", 32'(pass_o[0]), 1);
        chk("t3.cycles", 32'(cyc_o[0]), 3);
        // 4: timeout, and final match on the timeout edge
        go(1); idle(15);
        chk("t4.busy15", 32'(busy_o[0]), 1);
        chk("t4.cyc15", 32'(cyc_o[0]), 15);
        idle(1);
        chk("t4.fail", 32'(fail_o[0]), 1);
        chk("t4.code", 32'(code_o[0]), 2);
        chk("t4.cycles", 32'(cyc_o[0]), 15);
        go(1); idle(15); st(4, 1);
        chk("t4v.pass", 32'(pass_o[0]), 1);
        chk("t4v.fail", 32'(fail_o[0]), 0);
        // 5: tolerance disabled vs enabled at address 4
        prog(0, 8, 2); go(1); st(4, 1);
        chk("t5.u1_fail", 32'(fail_o[1]), 1);
        chk("t5.u1_code", 32'(code_o[1]), 1);
        chk("t5.u2_busy", 32'(busy_o[2]), 1);
        st(8, 2);
        chk("t5.u2_pass", 32'(pass_o[2]), 1);
        // 6: start and exp_we during RUN are ignored
        go(1); idle(3);
        exp_we = 1; exp_idx = 0; exp_addr = 12; exp_data = 12;
        go(1);
        exp_we = 0;
        chk("t6.busy", 32'(busy_o[0]), 1);
        chk("t6.cycles", 32'(cyc_o[0]), 4);
        st(8, 2);
        chk("t6.pass", 32'(pass_o[0]), 1);
        // mid-RUN reset takes effect without a clock edge
        go(1); idle(2);
        #2 reset = 0;
        #1;
        chk("t6r.busy", 32'(busy_o[0]), 0);
        chk("t6r.pass", 32'(pass_o[0]), 0);
        chk("t6r.fail", 32'(fail_o[0]), 0);
        chk("t6r.cycles", 32'(cyc_o[0]), 0);
        @(negedge clk);
        reset = 1;
        go(0);
        chk("t6e.fail", 32'(fail_o[0]), 1);
        chk("t6e.code", 32'(code_o[0]), 3);
        // table was cleared by reset: entry 0 is now (0,0)
        go(1); st(0, 0);
        chk("t6c.pass", 32'(pass_o[1]), 1);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
